// File: rtl/accel_data_server.sv
// Lockstep weight/input fetch engine with credit-controlled return FIFO.
// Optional overlap error counter: define ACCEL_OVERLAP_ERR_EN.
module accel_data_server #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_MAX  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] BaseAddr_W,
    input  logic [ADDR_W-1:0] BaseAddr_in,
    input  logic [4:0]        burst_len,
    input  logic              hold,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0] w_rdata,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              DVAL,
    output logic [DATA_W-1:0] weight_data,
    output logic [DATA_W-1:0] input_data,
    output logic              burst_done,
`ifdef ACCEL_OVERLAP_ERR_EN
    output logic [7:0]        err_count,
    output logic              err_flag,
`endif
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [5:0]          r_len;
    logic [5:0]          r_issued;
    logic [5:0]          r_presented;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_iaddr;
    logic [MEM_LAT-1:0]  r_vld;
    logic [MEM_LAT-1:0]  w_vld_nxt;
    logic [DATA_W-1:0]   r_fw [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fi [FIFO_DEPTH];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic [CW-1:0]       r_count;
    logic                r_dval;
    logic                r_done;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_idata;

    logic                w_accept;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_done;
    logic                w_credit;
    logic [CW-1:0]       w_inflight;
    logic [CW:0]         w_sum;
    logic [5:0]          w_len_in;

    assign w_len_in = (burst_len == 5'd0) ? 6'(BURST_MAX)
                                          : {1'b0, burst_len};
    assign w_push   = r_vld[MEM_LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    // Reads still in the memory pipe already own a FIFO slot.
    assign w_sum    = {1'b0, w_inflight} + {1'b0, r_count};
    assign w_credit = (w_sum < LP_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_pop       = !hold && (r_count != '0);
        unique case (r_state)
            S_IDLE: begin
                if (fetch_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = w_credit;
                if (w_issue && (r_issued == r_len - 6'd1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_presented == r_len - 6'd1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_vld_nxt    = r_vld << 1;
        w_vld_nxt[0] = w_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_presented <= '0;
            r_waddr     <= '0;
            r_iaddr     <= '0;
            r_vld       <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_dval      <= 1'b0;
            r_done      <= 1'b0;
            r_wdata     <= '0;
            r_idata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_vld_nxt;
            r_dval  <= w_pop;
            r_done  <= w_done;
            if (w_accept) begin
                r_waddr     <= BaseAddr_W;
                r_iaddr     <= BaseAddr_in;
                r_len       <= w_len_in;
                r_issued    <= '0;
                r_presented <= '0;
            end
            if (w_issue) begin
                r_waddr  <= r_waddr + 1'b1;
                r_iaddr  <= r_iaddr + 1'b1;
                r_issued <= r_issued + 6'd1;
            end
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp        <= r_rp + 1'b1;
                r_presented <= r_presented + 6'd1;
                r_wdata     <= r_fw[r_rp];
                r_idata     <= r_fi[r_rp];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fw[r_wp] <= w_rdata;
            r_fi[r_wp] <= in_rdata;
        end
    end

    assign w_rd_en     = w_issue;
    assign in_rd_en    = w_issue;
    assign w_rd_addr   = r_waddr;
    assign in_rd_addr  = r_iaddr;
    assign DVAL        = r_dval;
    assign weight_data = r_wdata;
    assign input_data  = r_idata;
    assign burst_done  = r_done;
    assign busy        = (r_state != S_IDLE) || r_done;

`ifdef ACCEL_OVERLAP_ERR_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (fetch_start && (r_state != S_IDLE)
                     && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
    assign err_flag  = (r_err_cnt != 8'd0);
`else
    // Requests arriving while busy are dropped without a trace.
`endif

endmodule

// File: tb/tb_accel_data_server.sv
// Randomized bench for accel_data_server against a queue-based pair model.
// Covers latency, credit, wrap, edge lengths, overlap and mid-burst reset.
module tb_accel_data_server;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int BMAX  = 16;

    logic          clk;
    logic          rst;
    logic          fetch_start;
    logic [AW-1:0] BaseAddr_W;
    logic [AW-1:0] BaseAddr_in;
    logic [4:0]    burst_len;
    logic          hold;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rdata;
    logic          in_rd_en;
    logic [AW-1:0] in_rd_addr;
    logic [DW-1:0] in_rdata;
    logic          DVAL;
    logic [DW-1:0] weight_data;
    logic [DW-1:0] input_data;
    logic          burst_done;
    logic          busy;
`ifdef ACCEL_OVERLAP_ERR_EN
    logic [7:0]    err_count;
    logic          err_flag;
`endif

    accel_data_server #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT),
        .FIFO_DEPTH(DEPTH), .BURST_MAX(BMAX)
    ) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start),
        .BaseAddr_W(BaseAddr_W), .BaseAddr_in(BaseAddr_in),
        .burst_len(burst_len), .hold(hold),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rdata(w_rdata),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rdata(in_rdata),
        .DVAL(DVAL), .weight_data(weight_data), .input_data(input_data),
        .burst_done(burst_done),
`ifdef ACCEL_OVERLAP_ERR_EN
        .err_count(err_count), .err_flag(err_flag),
`endif
        .busy(busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wmem(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] imem(input logic [15:0] a);
        return a * 16'd3 + 16'h0707;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memories; data outside the valid slot is poisoned.
    logic [DW-1:0] pw [LAT];
    logic [DW-1:0] pi [LAT];
    logic          pvw [LAT];
    logic          pvi [LAT];

    always @(posedge clk) begin
        pw[0]  <= wmem(w_rd_addr);
        pi[0]  <= imem(in_rd_addr);
        pvw[0] <= w_rd_en;
        pvi[0] <= in_rd_en;
        for (int i = 1; i < LAT; i++) begin
            pw[i]  <= pw[i-1];
            pi[i]  <= pi[i-1];
            pvw[i] <= pvw[i-1];
            pvi[i] <= pvi[i-1];
        end
    end

    assign w_rdata  = pvw[LAT-1] ? pw[LAT-1] : 16'hDEAD;
    assign in_rdata = pvi[LAT-1] ? pi[LAT-1] : 16'hBEEF;

    // Model state: expected pairs of the current burst and issue tracking.
    logic [31:0]   exp_q [$];
    logic [AW-1:0] exp_bw;
    logic [AW-1:0] exp_bi;
    int            iss_w;
    int            iss_i;
    int            dval_cnt;
    int            max_out;
    int            acc_cyc;
    int            err_exp = 0;
    bit            first_pending = 0;
    bit            done_seen = 0;
    bit            prev_done = 0;
    bit            prev_hold = 0;

    always @(negedge clk) begin
        logic [31:0] pr;
        bit          popped;
        int          out;
        popped = 0;
        if (!rst) begin
            if (DVAL) begin
                dval_cnt++;
                chk("hold_rule", 32'(prev_hold), 0);
                if (first_pending) begin
                    chk("latency", cyc - acc_cyc, LAT + 2);
                    first_pending = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_dval", 1, 0);
                end else begin
                    pr = exp_q.pop_front();
                    popped = 1;
                    chk("weight", 32'(weight_data), 32'(pr[31:16]));
                    chk("input", 32'(input_data), 32'(pr[15:0]));
                end
            end
            if (DVAL || burst_done) begin
                chk("done", 32'(burst_done),
                    32'(popped && exp_q.size() == 0));
            end
            if (burst_done) done_seen = 1;
            if (prev_done) chk("busy_drop", 32'(busy), 0);
            if (w_rd_en) begin
                out = iss_w - dval_cnt;
                if (out > max_out) max_out = out;
                chk("w_addr", 32'(w_rd_addr), 32'(16'(exp_bw + 16'(iss_w))));
                iss_w++;
            end
            if (in_rd_en) begin
                chk("in_addr", 32'(in_rd_addr), 32'(16'(exp_bi + 16'(iss_i))));
                iss_i++;
            end
        end
        prev_done = burst_done;
        prev_hold = hold;
    end

    // Called at posedge+1; returns at posedge+1 in the cycle after done.
    task automatic do_burst(input logic [15:0] bw, input logic [15:0] bi,
                            input logic [4:0] lf, input int hmode,
                            input bit ovl, input int rst_after);
        int n;
        int k;
        n = (lf == 5'd0) ? BMAX : int'(lf);
        BaseAddr_W  = bw;
        BaseAddr_in = bi;
        burst_len   = lf;
        fetch_start = 1'b1;
        acc_cyc = cyc + 1;
        exp_q.delete();
        for (int j = 0; j < n; j++) begin
            exp_q.push_back({wmem(16'(bw + 16'(j))), imem(16'(bi + 16'(j)))});
        end
        exp_bw = bw;
        exp_bi = bi;
        iss_w = 0;
        iss_i = 0;
        dval_cnt = 0;
        max_out = 0;
        first_pending = 1;
        done_seen = 0;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        BaseAddr_W  = 16'($urandom);
        BaseAddr_in = 16'($urandom);
        burst_len   = 5'($urandom);
        k = 0;
        while (!done_seen && k < 400) begin
            case (hmode)
                1:       hold = (k >= 5 && k <= 12);
                2:       hold = (k >= 5) && ($urandom_range(0, 2) == 0);
                default: hold = 1'b0;
            endcase
            if (ovl && (k == 3 || k == 6 || k == 9)) begin
                fetch_start = 1'b1;
                if (err_exp < 255) err_exp++;
            end else begin
                fetch_start = 1'b0;
            end
            if (rst_after > 0 && iss_w >= rst_after) begin
                rst  = 1'b1;
                hold = 1'b0;
                fetch_start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                first_pending = 0;
                err_exp = 0;
                @(negedge clk);
                chk("rst_dval", 32'(DVAL), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_rden", 32'(w_rd_en), 0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            k++;
        end
        hold = 1'b0;
        fetch_start = 1'b0;
        if (!done_seen) chk("timeout", 0, 1);
        chk("nrd_w", iss_w, n);
        chk("nrd_in", iss_i, n);
        chk("pairs", dval_cnt, n);
        chk("credit", 32'(max_out < DEPTH), 1);
    endtask

    initial begin
        rst = 1'b1;
        fetch_start = 1'b0;
        BaseAddr_W = '0;
        BaseAddr_in = '0;
        burst_len = '0;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_DVAL", 32'(DVAL), 0);
        chk("rst_busy0", 32'(busy), 0);
        chk("rst_done", 32'(burst_done), 0);
        chk("rst_wen", 32'(w_rd_en), 0);
        chk("rst_wdat", 32'(weight_data), 0);
        chk("rst_idat", 32'(input_data), 0);
`ifdef ACCEL_OVERLAP_ERR_EN
        chk("rst_err", 32'(err_count), 0);
`endif
        @(posedge clk); #1;

        do_burst(16'h0100, 16'h0200, 5'd16, 0, 0, 0);
        do_burst(16'($urandom), 16'($urandom), 5'd16, 1, 0, 0);
        do_burst(16'hFFFE, 16'hFFFF, 5'd4, 0, 0, 0);
        do_burst(16'($urandom), 16'($urandom), 5'd0, 0, 0, 0);
        do_burst(16'($urandom), 16'($urandom), 5'd1, 0, 0, 0);
        do_burst(16'($urandom), 16'($urandom), 5'd16, 0, 1, 0);
`ifdef ACCEL_OVERLAP_ERR_EN
        chk("err_count", 32'(err_count), err_exp);
        chk("err_flag", 32'(err_flag), 32'(err_exp != 0));
`endif
        do_burst(16'($urandom), 16'($urandom), 5'd16, 0, 0, 5);
        do_burst(16'h0100, 16'h0200, 5'd8, 0, 0, 0);

        for (int b = 0; b < 20; b++) begin
            do_burst(16'($urandom), 16'($urandom),
                     5'($urandom_range(0, BMAX)),
                     $urandom_range(0, 2), 0, 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/accel_data_server.md
Name: accel_data_server

Overview:
- Responder end of the accelerator address/DVAL interface.
- Accepts a fetch request from the accelerator FSM: a base weight address, a base input address and a burst length.
- Reads the weight memory and the input buffer in lockstep through two fixed-latency read ports, buffers the returned pairs in a credit-controlled FIFO, and presents one (weight, input) pair per cycle qualified by DVAL.
- Sits between the accelerator FSM / MAC array and the on-chip weight and input RAMs.

Parameters:
- DATA_W, 16, width of weight and input words.
- ADDR_W, 16, address width of both memories.
- MEM_LAT, 2, read latency in cycles from rd_en to rdata valid (1..4).
- FIFO_DEPTH, 4, return FIFO entries; must be >= MEM_LAT+1, power of two.
- BURST_MAX, 16, largest legal burst length (parallel multipliers per PE group).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  one-cycle request strobe.
- BaseAddr_W  in  ADDR_W  weight start address, sampled on an accepted fetch_start.
- BaseAddr_in  in  ADDR_W  input start address, sampled on an accepted fetch_start.
- burst_len  in  5  pairs to fetch (1..BURST_MAX); 0 is treated as BURST_MAX.
- hold  in  1  consumer stall; no pair is presented while high.
- w_rd_en  out  1  weight memory read strobe.
- w_rd_addr  out  ADDR_W  weight read address.
- w_rdata  in  DATA_W  weight read data, valid MEM_LAT cycles after w_rd_en.
- in_rd_en  out  1  input buffer read strobe (always equal to w_rd_en).
- in_rd_addr  out  ADDR_W  input read address.
- in_rdata  in  DATA_W  input read data, same latency.
- DVAL  out  1  weight_data/input_data valid this cycle.
- weight_data  out  DATA_W  weight word.
- input_data  out  DATA_W  input word.
- burst_done  out  1  one-cycle pulse in the cycle the last pair of a burst is presented.
- busy  out  1  high from acceptance until the cycle after burst_done.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, all counters 0.
- States:
  - IDLE: fetch_start -> latch the addresses and len, go to ISSUE.
  - ISSUE: issue a read when credit is available; after len reads go to DRAIN.
  - DRAIN: wait until len pairs have been presented, then go to IDLE.
- Acceptance: fetch_start is accepted only in IDLE. In any other state it is ignored with no side effects.
- Credit rule: issue only when inflight + fifo_count < FIFO_DEPTH. inflight is the popcount of a MEM_LAT-deep valid shift register. The FIFO can never overflow.
- Addressing: the read address equals the base address for the first read and increments by 1 per issued read. It wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
- Same-cycle issue: both memories are read in the same cycle with the same offset. w_rd_en == in_rd_en always.
- Return: the pair is written to the FIFO when the shift register tap is set, i.e. MEM_LAT cycles after the read.
- Output stage (registered):
  - When !hold and the FIFO is non-empty, pop into weight_data/input_data and assert DVAL the next cycle.
  - DVAL is low in any cycle with no pop; the data outputs hold their last value.
- Latency: with hold low and the FIFO empty, the first DVAL comes MEM_LAT+2 cycles after the fetch_start edge (1 accept, 1 issue, MEM_LAT memory, then registered output).
- Throughput: 1 pair/cycle when hold is low.
- Stall behaviour: while hold is high, issue continues until credit runs out, then stops. Releasing hold resumes at 1 pair/cycle with no lost or duplicated pairs.
- Simultaneous push and pop: fifo_count is unchanged. A pop from an empty FIFO never happens. A same-cycle push into a full FIFO is impossible by the credit rule.
- burst_done coincides with DVAL of the len-th pair. In the same cycle the FSM returns to IDLE, so fetch_start in the cycle after burst_done is accepted.
- Reset mid-burst: the FSM goes to IDLE and the FIFO and shift register clear. Memory data returning after reset is discarded, because the shift register was cleared. No DVAL follows reset.

Optional Feature:
- Macro: ACCEL_OVERLAP_ERR_EN.
- When defined:
  - Adds output err_count[7:0], reset 0.
  - It increments on every fetch_start seen while not in IDLE and saturates at 0xFF.
  - Adds output err_flag, high whenever err_count != 0.
- When undefined: neither port exists and overlapping requests are silently ignored.

Test Plan:
- Basic burst: MEM_LAT=2, BaseAddr_W=0x0100, BaseAddr_in=0x0200, len=16, hold=0 -> first DVAL 4 cycles after fetch_start, then 16 consecutive DVALs with weight_data = mem_w[0x100..0x10F] and input_data = mem_in[0x200..0x20F]; burst_done on the 16th; busy drops the next cycle.
- Backpressure: len=16, hold high for cycles 5-12 -> at most FIFO_DEPTH reads outstanding, no DVAL while hold=1, all 16 pairs delivered in order exactly once.
- Address wrap: BaseAddr_W=0xFFFE, len=4 -> w_rd_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Edge lengths: burst_len=0 -> 16 pairs; burst_len=1 -> single DVAL with burst_done in the same cycle.
- Overlap: fetch_start repeated 3 times mid-burst -> burst unaffected; with ACCEL_OVERLAP_ERR_EN, err_count=3 and err_flag=1.
- Reset mid-burst: rst asserted after 5 reads issued -> no DVAL after reset, busy=0; a new fetch_start the cycle after reset deasserts completes a clean burst.
